// File: rtl/spi_burst_ram_slave_pkg.sv
// Shared types and constants for the SPI burst RAM slave.
// Frame layout: CMD_W command bits, ADDR_W address bits, then the data words.
package spi_burst_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddr,
    StWrite,
    StReadWait,
    StRead,
    StIgnore
  } state_e;

  localparam int unsigned CMD_W = 2;
  localparam logic [CMD_W-1:0] CMD_WR = 2'b00;
  localparam logic [CMD_W-1:0] CMD_RD = 2'b01;

endpackage

// File: rtl/spi_burst_ram_slave_if.sv
// Serial frame interface of the SPI burst RAM slave.
// The host side (master) drives select and data in; the slave drives data out and status.
interface spi_burst_ram_slave_if;
  logic SS_n;
  logic MOSI;
  logic MISO;
  logic busy;
  logic frame_done;
  logic frame_err;

  modport master (
    output SS_n,
    output MOSI,
    input  MISO,
    input  busy,
    input  frame_done,
    input  frame_err
  );

  modport slave (
    input  SS_n,
    input  MOSI,
    output MISO,
    output busy,
    output frame_done,
    output frame_err
  );
endinterface

// File: rtl/spi_burst_ram_slave_ram.sv
// Single-port synchronous RAM with a registered read port (one cycle of latency).
// A write has priority over a read in the same cycle; the read data holds when idle.
module spi_burst_ram #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned MEM_DEPTH = 256
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end else if (re_i) begin
      rdata_o <= mem_q[addr_i];
    end
  end

endmodule

// File: rtl/spi_burst_ram_slave.sv
// Serial slave sampled on clk that fronts a synchronous RAM, with burst read/write,
// address auto-increment wrapping at MEM_DEPTH, and end-of-frame done/error pulses.
module spi_burst_ram_slave
  import spi_burst_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned MEM_DEPTH = 256
) (
  input logic                 clk,
  input logic                 rst,
  spi_burst_ram_slave_if.slave bus
);

  localparam int unsigned MaxW = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int unsigned CntW = $clog2(MaxW + 1);

  state_e            state_q;
  logic [CMD_W-1:0]  cmd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [CntW-1:0]   bit_cnt_q;
  logic              wr_en_q;
  logic              frame_done_q;
  logic              frame_err_q;

  logic [ADDR_W-1:0] addr_full;
  logic [ADDR_W-1:0] addr_mod;
  logic [ADDR_W-1:0] addr_next;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] data_full;
  logic [DATA_W-1:0] rd_data;
  logic              addr_last;
  logic              data_last;
  logic              rd_prefetch;
  logic              rd_en;

  always_comb begin
    addr_full   = ADDR_W'({addr_q, bus.MOSI});
    addr_mod    = ADDR_W'(32'(addr_full) % MEM_DEPTH);
    addr_next   = (addr_q == ADDR_W'(MEM_DEPTH - 1)) ? '0 : addr_q + 1'b1;
    data_full   = DATA_W'({shift_q, bus.MOSI});
    addr_last   = (bit_cnt_q == CntW'(ADDR_W - 1));
    data_last   = (bit_cnt_q == CntW'(DATA_W - 1));
    rd_prefetch = (bit_cnt_q == CntW'(DATA_W - 2));
    // Next word is fetched one bit early so its MSB is ready on the word boundary.
    rd_en       = (state_q == StReadWait) || ((state_q == StRead) && rd_prefetch);
    if (wr_en_q) begin
      ram_addr = wr_addr_q;
    end else if (state_q == StRead) begin
      ram_addr = addr_next;
    end else begin
      ram_addr = addr_q;
    end
  end

  spi_burst_ram #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (wr_en_q),
    .re_i    (rd_en),
    .addr_i  (ram_addr),
    .wdata_i (wr_data_q),
    .rdata_o (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cmd_q        <= '0;
      addr_q       <= '0;
      wr_addr_q    <= '0;
      shift_q      <= '0;
      wr_data_q    <= '0;
      bit_cnt_q    <= '0;
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      wr_en_q      <= 1'b0;
      if (bus.SS_n) begin
        state_q   <= StIdle;
        bit_cnt_q <= '0;
        case (state_q)
          StIdle: ;
          StCmd, StAddr, StIgnore: frame_err_q <= 1'b1;
          StWrite: begin
            if (bit_cnt_q == '0) frame_done_q <= 1'b1;
            else                 frame_err_q  <= 1'b1;
          end
          // Reads are non-destructive, so stopping anywhere in them is clean.
          default: frame_done_q <= 1'b1;
        endcase
      end else begin
        unique case (state_q)
          StIdle: begin
            cmd_q   <= {cmd_q[0], bus.MOSI};
            state_q <= StCmd;
          end
          StCmd: begin
            cmd_q     <= {cmd_q[0], bus.MOSI};
            bit_cnt_q <= '0;
            state_q   <= StAddr;
          end
          StAddr: begin
            if (addr_last) begin
              addr_q    <= addr_mod;
              bit_cnt_q <= '0;
              if (cmd_q == CMD_WR)      state_q <= StWrite;
              else if (cmd_q == CMD_RD) state_q <= StReadWait;
              else                      state_q <= StIgnore;
            end else begin
              addr_q    <= addr_full;
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
          StWrite: begin
            shift_q <= data_full;
            if (data_last) begin
              wr_en_q   <= 1'b1;
              wr_data_q <= data_full;
              wr_addr_q <= addr_q;
              addr_q    <= addr_next;
              bit_cnt_q <= '0;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
          StReadWait: begin
            bit_cnt_q <= '0;
            state_q   <= StRead;
          end
          StRead: begin
            if (bit_cnt_q == '0) shift_q <= {rd_data[DATA_W-2:0], 1'b0};
            else                 shift_q <= {shift_q[DATA_W-2:0], 1'b0};
            if (data_last) begin
              addr_q    <= addr_next;
              bit_cnt_q <= '0;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
          StIgnore: ;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  // MISO is a pure function of flops: the RAM output register supplies each word's MSB.
  assign bus.MISO       = (state_q != StRead)  ? 1'b0 :
                          (bit_cnt_q == '0)    ? rd_data[DATA_W-1] : shift_q[DATA_W-1];
  assign bus.busy       = (state_q != StIdle);
  assign bus.frame_done = frame_done_q;
  assign bus.frame_err  = frame_err_q;

endmodule

// File: tb/tb_spi_burst_ram_slave.sv
// Directed bench for spi_burst_ram_slave: a default-size instance and a MEM_DEPTH=200 one,
// with a RAM model and a queue of expected MISO bits checked as the read stream emerges.
module tb_spi_burst_ram_slave;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic ss_n = 1'b1;
  logic mosi = 1'b0;
  logic sel  = 1'b0;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;

  logic [7:0] mdl0 [256];
  logic [7:0] mdl1 [200];
  logic       sb [$];

  always #5 clk = ~clk;

  spi_burst_ram_slave_if bus0 ();
  spi_burst_ram_slave_if bus1 ();

  assign bus0.SS_n = sel ? 1'b1 : ss_n;
  assign bus0.MOSI = mosi;
  assign bus1.SS_n = sel ? ss_n : 1'b1;
  assign bus1.MOSI = mosi;

  spi_burst_ram_slave #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(256)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  spi_burst_ram_slave #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(200)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  wire miso_s = sel ? bus1.MISO       : bus0.MISO;
  wire busy_s = sel ? bus1.busy       : bus0.busy;
  wire done_s = sel ? bus1.frame_done : bus0.frame_done;
  wire err_s  = sel ? bus1.frame_err  : bus0.frame_err;

  always @(posedge clk) begin
    if (done_s === 1'b1) done_cnt <= done_cnt + 1;
    if (err_s === 1'b1)  err_cnt  <= err_cnt + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int depth_of();
    return sel ? 200 : 256;
  endfunction

  task automatic mdl_write(input int a, input logic [7:0] v);
    if (sel) mdl1[a] = v;
    else     mdl0[a] = v;
  endtask

  function automatic logic [7:0] mdl_read(input int a);
    return sel ? mdl1[a] : mdl0[a];
  endfunction

  task automatic send_bit(input logic b);
    ss_n = 1'b0;
    mosi = b;
    @(negedge clk);
  endtask

  task automatic header(input logic [1:0] cmd, input logic [7:0] addr);
    send_bit(cmd[1]);
    send_bit(cmd[0]);
    for (int i = 7; i >= 0; i--) send_bit(addr[i]);
  endtask

  task automatic end_frame(input string tag, input logic exp_done, input logic exp_err);
    int d0;
    int e0;
    d0   = done_cnt;
    e0   = err_cnt;
    ss_n = 1'b1;
    mosi = 1'b0;
    @(negedge clk);
    chk({tag, " busy after SS_n rise"}, busy_s, 1'b0);
    chk({tag, " frame_done"}, done_s, exp_done);
    chk({tag, " frame_err"}, err_s, exp_err);
    @(negedge clk);
    @(negedge clk);
    chk({tag, " frame_done pulse count"}, done_cnt - d0, exp_done);
    chk({tag, " frame_err pulse count"}, err_cnt - e0, exp_err);
  endtask

  task automatic write_frame(input string tag, input int addr, input int n,
                             input logic [7:0] w0, input logic [7:0] w1);
    logic [7:0] w;
    header(2'b00, 8'(addr));
    for (int k = 0; k < n; k++) begin
      w = (k == 0) ? w0 : w1;
      for (int b = 7; b >= 0; b--) send_bit(w[b]);
      mdl_write((addr + k) % depth_of(), w);
    end
    end_frame(tag, 1'b1, 1'b0);
  endtask

  task automatic read_frame(input string tag, input int addr, input int n);
    logic [7:0] w;
    logic       exp_bit;
    for (int k = 0; k < n; k++) begin
      w = mdl_read((addr + k) % depth_of());
      for (int b = 7; b >= 0; b--) sb.push_back(w[b]);
    end
    header(2'b01, 8'(addr));
    chk({tag, " MISO in dummy cycle"}, miso_s, 1'b0);
    send_bit(1'($urandom));
    for (int i = 0; i < n * 8; i++) begin
      if (sb.size() == 0) begin
        chk({tag, " scoreboard underflow"}, 32'd0, 32'd1);
      end else begin
        exp_bit = sb.pop_front();
        chk($sformatf("%s MISO bit %0d", tag, i), miso_s, exp_bit);
      end
      chk($sformatf("%s busy bit %0d", tag, i), busy_s, 1'b1);
      send_bit(1'($urandom));
    end
    end_frame(tag, 1'b1, 1'b0);
  endtask

  initial begin
    int d0;
    int e0;
    logic exp_bit;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset MISO", miso_s, 1'b0);
    chk("reset busy", busy_s, 1'b0);
    chk("reset frame_done", done_s, 1'b0);
    chk("reset frame_err", err_s, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Two-word burst write, then streamed readback of both words.
    write_frame("wr 0x10", 'h10, 2, 8'hA5, 8'h3C);
    read_frame("rd 0x10", 'h10, 2);

    // A 5-bit partial word must not reach the RAM.
    write_frame("wr 0x10 FF", 'h10, 1, 8'hFF, 8'h00);
    header(2'b00, 8'h10);
    for (int i = 0; i < 5; i++) send_bit(1'b0);
    end_frame("partial wr", 1'b0, 1'b1);
    read_frame("rd after partial", 'h10, 1);

    // Reserved command: data ignored, MISO held low.
    write_frame("wr 0x00", 'h00, 1, 8'h5A, 8'h00);
    header(2'b11, 8'h00);
    chk("ignore MISO after header", miso_s, 1'b0);
    for (int i = 0; i < 8; i++) begin
      send_bit(1'b1);
      chk($sformatf("ignore MISO bit %0d", i), miso_s, 1'b0);
    end
    end_frame("ignore", 1'b0, 1'b1);
    read_frame("rd after ignore", 'h00, 1);

    // Reset at bit 3 of a read.
    sb.push_back(1'b0); sb.push_back(1'b0); sb.push_back(1'b1);
    header(2'b01, 8'h11);
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) begin
      exp_bit = sb.pop_front();
      chk($sformatf("rst-rd MISO bit %0d", i), miso_s, exp_bit);
      send_bit(1'b0);
    end
    d0   = done_cnt;
    e0   = err_cnt;
    rst  = 1'b1;
    ss_n = 1'b1;
    @(negedge clk);
    chk("rst-rd MISO after reset", miso_s, 1'b0);
    chk("rst-rd busy after reset", busy_s, 1'b0);
    rst = 1'b0;
    sb.delete();
    repeat (3) @(negedge clk);
    chk("rst-rd no frame_done", done_cnt - d0, 0);
    chk("rst-rd no frame_err", err_cnt - e0, 0);
    read_frame("rd 0x11 after reset", 'h11, 1);

    // Non-power-of-two depth: burst wraps from 199 to 0.
    sel = 1'b1;
    @(negedge clk);
    write_frame("d200 wr 199", 199, 2, 8'h11, 8'h22);
    read_frame("d200 rd 199", 199, 2);
    read_frame("d200 rd 0", 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
